// File: rtl/flag_stack_register.sv
// Status-flag unit: captures V/C/N/P/Z from the ALU result bus with a per-flag mask,
// supports direct software write and a LIFO save/restore stack of DEPTH flag contexts.
module flag_stack_register #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enaf,
    input  logic [4:0]                 upd_mask,
    input  logic [WIDTH-1:0]           dataa,
    input  logic                       carry,
    input  logic                       ovf,
    input  logic                       wr,
    input  logic [4:0]                 din,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic                       C,
    output logic                       N,
    output logic                       P,
    output logic                       Z,
    output logic                       V,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = AW + 1;

    // Flag vector order is {V,C,N,P,Z}, matching upd_mask and din.
    logic [4:0]    flags_q, flags_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic [4:0]    stack_q [DEPTH];

    logic          push_ok, pop_ok, err_set;
    logic [4:0]    cap;
    logic [AW-1:0] wr_idx, rd_idx;

    assign full  = (depth_q == DW'(DEPTH));
    assign empty = (depth_q == '0);

    assign push_ok = push & ~pop & ~full;
    assign pop_ok  = pop & ~push & ~empty;
    assign err_set = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

    assign wr_idx = depth_q[AW-1:0];
    assign rd_idx = AW'(depth_q - DW'(1));

    assign cap = {ovf, carry, dataa[WIDTH-1], ~^dataa, (dataa == '0)};

    always_comb begin
        flags_d = flags_q;
        depth_d = depth_q;
        if (pop_ok) begin
            flags_d = stack_q[rd_idx];
        end else if (wr) begin
            flags_d = din;
        end else if (enaf) begin
            flags_d = (flags_q & ~upd_mask) | (cap & upd_mask);
        end
        if (push_ok) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DW'(1);
        end
        // A new error in the same cycle wins over the clear.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset on the storage.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stack_q[wr_idx] <= flags_q;
        end
    end

    assign {V, C, N, P, Z} = flags_q;
    assign depth = depth_q;
    assign err   = err_q;

endmodule

// File: tb/tb_flag_stack_register.sv
// Bench for flag_stack_register: directed vector table, directed WIDTH=16 / async reset
// sequence, and randomized traffic against a queue-based reference model.
module tb_flag_stack_register;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enaf, carry, ovf, wr, push, pop, err_clr;
    logic [4:0]  upd_mask, din;
    logic [7:0]  dataa8;
    logic [15:0] dataa16;

    logic        c8, n8, p8, z8, v8, full8, empty8, err8;
    logic [2:0]  depth8;
    logic        c16, n16, p16, z16, v16, full16, empty16, err16;
    logic [2:0]  depth16;

    int checks = 0;
    int errors = 0;

    flag_stack_register #(.WIDTH(8), .DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .enaf(enaf), .upd_mask(upd_mask), .dataa(dataa8),
        .carry(carry), .ovf(ovf), .wr(wr), .din(din), .push(push), .pop(pop),
        .err_clr(err_clr), .C(c8), .N(n8), .P(p8), .Z(z8), .V(v8), .depth(depth8),
        .full(full8), .empty(empty8), .err(err8)
    );

    flag_stack_register #(.WIDTH(16), .DEPTH(DEPTH)) dut16 (
        .clk(clk), .rst(rst), .enaf(enaf), .upd_mask(upd_mask), .dataa(dataa16),
        .carry(carry), .ovf(ovf), .wr(wr), .din(din), .push(push), .pop(pop),
        .err_clr(err_clr), .C(c16), .N(n16), .P(p16), .Z(z16), .V(v16), .depth(depth16),
        .full(full16), .empty(empty16), .err(err16)
    );

    always #5 clk = ~clk;

    // Reference model of the WIDTH=8 instance.
    logic [4:0] m_flags;
    logic       m_err;
    logic [4:0] m_stk[$];

    task automatic model_reset();
        m_flags = '0;
        m_err   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step();
        logic [4:0] cap, nf;
        logic       eset;
        cap[4] = ovf;
        cap[3] = carry;
        cap[2] = dataa8[7];
        cap[1] = ($countones(dataa8) % 2 == 0);
        cap[0] = (dataa8 == 8'd0);
        eset = (push && pop) || (push && !pop && m_stk.size() == DEPTH)
            || (pop && !push && m_stk.size() == 0);
        nf = m_flags;
        if (pop && !push && m_stk.size() > 0) nf = m_stk.pop_back();
        else if (wr) nf = din;
        else if (enaf) nf = (m_flags & ~upd_mask) | (cap & upd_mask);
        if (push && !pop && m_stk.size() < DEPTH) m_stk.push_back(m_flags);
        m_err   = eset || (m_err && !err_clr);
        m_flags = nf;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle();
        enaf = 0; upd_mask = 0; dataa8 = 0; dataa16 = 0; carry = 0; ovf = 0;
        wr = 0; din = 0; push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string nm, input logic [4:0] ef, input int ed,
                               input logic ee);
        chk({nm, ".flags"}, {v8, c8, n8, p8, z8}, ef);
        chk({nm, ".depth"}, depth8, ed);
        chk({nm, ".full"}, full8, ed == DEPTH);
        chk({nm, ".empty"}, empty8, ed == 0);
        chk({nm, ".err"}, err8, ee);
    endtask

    typedef struct {
        string      nm;
        logic       enaf;
        logic [4:0] mask;
        logic [7:0] dataa;
        logic       carry, ovf, wr;
        logic [4:0] din;
        logic       push, pop, clr;
        logic [4:0] exp_flags;
        int         exp_depth;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        //                nm        enaf mask   dataa  c  o  wr din    pu po cl  flags  d  e
        vecs.push_back('{"cap00",   1, 5'h1f, 8'h00, 1, 0, 0, 5'h00, 0, 0, 0, 5'h0b, 0, 0});
        vecs.push_back('{"cap83",   1, 5'h1f, 8'h83, 0, 1, 0, 5'h00, 0, 0, 0, 5'h14, 0, 0});
        vecs.push_back('{"wr1f",    0, 5'h00, 8'h00, 0, 0, 1, 5'h1f, 0, 0, 0, 5'h1f, 0, 0});
        vecs.push_back('{"maskz",   1, 5'h01, 8'h05, 0, 0, 0, 5'h00, 0, 0, 0, 5'h1e, 0, 0});
        vecs.push_back('{"wr01",    0, 5'h00, 8'h00, 0, 0, 1, 5'h01, 0, 0, 0, 5'h01, 0, 0});
        vecs.push_back('{"push1",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h01, 1, 0});
        vecs.push_back('{"wr10",    0, 5'h00, 8'h00, 0, 0, 1, 5'h10, 0, 0, 0, 5'h10, 1, 0});
        vecs.push_back('{"push2",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h10, 2, 0});
        vecs.push_back('{"wr00",    0, 5'h00, 8'h00, 0, 0, 1, 5'h00, 0, 0, 0, 5'h00, 2, 0});
        vecs.push_back('{"pop1",    1, 5'h1f, 8'h00, 1, 1, 1, 5'h0f, 0, 1, 0, 5'h10, 1, 0});
        vecs.push_back('{"pop2",    0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 1, 0, 5'h01, 0, 0});
        vecs.push_back('{"pushcap", 1, 5'h1f, 8'h01, 0, 0, 0, 5'h00, 1, 0, 0, 5'h00, 1, 0});
        vecs.push_back('{"popcap",  0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 1, 0, 5'h01, 0, 0});
        vecs.push_back('{"popempt", 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 1, 0, 5'h01, 0, 1});
        vecs.push_back('{"clr",     0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 0, 1, 5'h01, 0, 0});
        vecs.push_back('{"fill1",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h01, 1, 0});
        vecs.push_back('{"fill2",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h01, 2, 0});
        vecs.push_back('{"fill3",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h01, 3, 0});
        vecs.push_back('{"fill4",   0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 0, 5'h01, 4, 0});
        vecs.push_back('{"ovfl",    0, 5'h00, 8'h00, 0, 0, 1, 5'h1a, 1, 0, 0, 5'h1a, 4, 1});
        vecs.push_back('{"clr2",    0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 0, 1, 5'h1a, 4, 0});
        vecs.push_back('{"pushpop", 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 1, 0, 5'h1a, 4, 1});
        vecs.push_back('{"clrwin",  0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 1, 0, 1, 5'h1a, 4, 1});
        vecs.push_back('{"popfull", 0, 5'h00, 8'h00, 0, 0, 0, 5'h00, 0, 1, 1, 5'h01, 3, 0});

        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 5'h00, 0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            enaf = vecs[i].enaf; upd_mask = vecs[i].mask; dataa8 = vecs[i].dataa;
            carry = vecs[i].carry; ovf = vecs[i].ovf; wr = vecs[i].wr; din = vecs[i].din;
            push = vecs[i].push; pop = vecs[i].pop; err_clr = vecs[i].clr;
            tick();
            check_state(vecs[i].nm, vecs[i].exp_flags, vecs[i].exp_depth, vecs[i].exp_err);
        end
        idle();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            enaf = ($urandom_range(0, 1) == 1);
            upd_mask = 5'($urandom);
            dataa8 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            carry = 1'($urandom);
            ovf = 1'($urandom);
            wr = ($urandom_range(0, 5) == 0);
            din = 5'($urandom);
            push = ($urandom_range(0, 2) == 0);
            pop = ($urandom_range(0, 2) == 0);
            err_clr = ($urandom_range(0, 3) == 0);
            tick();
            check_state("rand", m_flags, m_stk.size(), m_err);
        end
        idle();

        // WIDTH=16 capture and asynchronous reset mid-cycle.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        enaf = 1; upd_mask = 5'h1f; dataa16 = 16'h8001;
        tick();
        chk("w16.N", n16, 1'b1);
        chk("w16.P", p16, 1'b1);
        chk("w16.Z", z16, 1'b0);
        dataa16 = 16'h0000;
        tick();
        chk("w16.Z0", z16, 1'b1);
        chk("w16.P0", p16, 1'b1);
        idle();
        push = 1;
        tick();
        tick();
        push = 0;
        chk("w16.depth2", depth16, 3'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.depth16", depth16, 3'd0);
        chk("arst.flags16", {v16, c16, n16, p16, z16}, 5'h00);
        chk("arst.empty16", empty16, 1'b1);
        chk("arst.depth8", depth8, 3'd0);
        #1;
        rst = 1'b0;
        model_reset();
        pop = 1;
        tick();
        pop = 0;
        chk("arst.popempty", err16, 1'b1);
        chk("arst.depthkeep", depth16, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
